mul_div_unit: RTL and testbench
===============================

Name: mul_div_unit

Overview:
- Iterative 16-bit signed multiply/divide unit in the execute stage, directly upstream of the register file write port.
- Produces one 32-bit result per operation: high half is written to R0, low half to the destination register.
- Stalls the pipeline via busy while iterating.
- Drives the register file's write_en, R0_en, write_address and write_data inputs directly.

Parameters:
- WIDTH, 16, operand width; result is 2*WIDTH.
- ITER, WIDTH, iterations per operation; fixed equal to WIDTH.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- halt_sys  in  1  system halt; freezes all state.
- start  in  1  operation request; sampled only in IDLE.
- op  in  1  0 = MUL, 1 = DIV.
- dest_addr  in  4  destination register for the low half.
- opa  in  16  multiplicand or dividend, two's complement.
- opb  in  16  multiplier or divisor, two's complement.
- busy  out  1  high from acceptance until return to IDLE.
- write_en  out  1  one-cycle result-valid and write strobe.
- R0_en  out  1  high with write_en; selects the high half into R0.
- write_address  out  4  latched dest_addr.
- write_data  out  32  MUL: {product[31:16], product[15:0]}; DIV: {remainder, quotient}.
- div_zero  out  1  sticky flag for the last op; set on DIV with opb = 0.

Behaviour:
- Reset (synchronous): state IDLE. busy, write_en, R0_en, div_zero = 0. write_address = 0, write_data = 0.
- States: IDLE -> CALC -> FIX -> DONE -> IDLE.
- IDLE:
  - start = 1 and halt_sys = 0 at edge E0: latch op and dest_addr, latch |opa| and |opb|, and latch the result sign.
  - Result sign for MUL: sign(a) XOR sign(b). For DIV, the quotient sign is sign(a) XOR sign(b) and the remainder sign is sign(a).
  - Clear counter; go to CALC; busy = 1 from E0.
- CALC:
  - One iteration per edge; 16 iterations, at E1..E16. After the 16th, go to FIX.
  - MUL: unsigned shift-add on magnitudes, 32-bit accumulator.
  - DIV: restoring division on magnitudes, 16-bit partial remainder plus one guard bit.
- FIX (edge E17):
  - Apply two's-complement negation per the latched signs.
  - Load write_data, write_address = dest, R0_en = 1, write_en = 1. Go to DONE.
- DONE:
  - write_en and R0_en are high for exactly the cycle after E17.
  - At E18: write_en = 0, R0_en = 0, go to IDLE. busy falls at E18.
  - write_data and write_address hold until the next FIX.
- Latency: write_en is asserted 17 cycles after the accepting edge. Next start is accepted no earlier than E18.
- halt_sys = 1 in any state: no state, counter, datapath or output change at that edge. In DONE, write_en is held high until the first edge with halt_sys = 0, because the register file ignores writes while halted.
- start while busy: ignored, no queuing. start in IDLE with halt_sys = 1: not accepted.
- DIV semantics: quotient truncates toward zero; remainder takes the dividend's sign.
- Divide by zero: opb = 0 gives quotient 16'hFFFF, remainder = opa, div_zero = 1. Still 17-cycle latency.
- Overflow: -32768 / -1 gives quotient 16'h8000, remainder 0, no flag.
- MUL never overflows (full 32-bit product).
- div_zero updates at FIX and clears at FIX of a non-faulting op.
- dest_addr = 0 is legal. The register file gives the low half priority over the R0 high-half write.
- rst mid-operation (any state): next edge returns to reset values. No write_en is ever produced for the aborted op.

Decomposition:
- mdu_pkg holds:
  - typedef enum logic [1:0] mdu_state_t {IDLE, CALC, FIX, DONE}
  - typedef enum logic mdu_op_t {MDU_MUL, MDU_DIV}
  - localparams WIDTH = 16, ITER = 16, CNT_W = 5.
- Sub-module mdu_iter_core: the single-step combinational datapath. It takes op, the accumulator or partial remainder, and the operand magnitude, and returns the next accumulator/remainder and quotient bit.
- The top level owns the FSM, counter, sign handling and output registers.

Test Plan:
- MUL 3 * -4 (opa 16'h0003, opb 16'hFFFC, dest 5): 17 cycles after accept, write_en = 1 and R0_en = 1 for one cycle, write_data = 32'hFFFF_FFF4, write_address = 5.
- MUL 16'h7FFF * 16'h7FFF -> write_data 32'h3FFF_0001. MUL 16'h8000 * 16'h8000 -> 32'h4000_0000.
- DIV -7 / 2 -> write_data 32'hFFFF_FFFD (remainder -1, quotient -3), div_zero = 0. DIV 100 / 7 -> 32'h0002_000E.
- DIV 100 / 0 -> write_data 32'h0064_FFFF, div_zero = 1. A following DIV 9 / 3 clears div_zero, write_data 32'h0000_0003. DIV -32768 / -1 -> 32'h0000_8000.
- Halt and reset:
  - halt_sys high 5 cycles during CALC: write_en arrives 22 cycles after accept.
  - halt_sys high 3 cycles in DONE: write_en stays high 4 cycles total.
  - start pulsed while busy: ignored.
- rst asserted 8 cycles after accept: busy = 0 and all outputs zero after the next edge, no write_en. A new start then completes normally in 17 cycles.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared types and constants for the iterative signed multiply/divide unit.
package mdu_pkg;
   localparam int WIDTH = 16;
   localparam int ITER  = 16;
   localparam int CNT_W = 5;

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} mdu_state_t;
   typedef enum logic {MDU_MUL, MDU_DIV} mdu_op_t;

   // Magnitude of a two's-complement value; -32768 maps to unsigned 32768.
   function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
      return v[WIDTH-1] ? -v : v;
   endfunction
endpackage

// File: rtl/mdu_iter_core.sv
// One combinational step of unsigned shift-add multiply or restoring divide.
module mdu_iter_core
   import mdu_pkg::*;
(
   input  mdu_op_t            op,
   input  logic [2*WIDTH-1:0] acc,
   input  logic [WIDTH-1:0]   b_mag,
   output logic [2*WIDTH-1:0] acc_next,
   output logic               q_bit
);
   logic [WIDTH:0]   mul_sum;
   logic [WIDTH:0]   rem_trial;
   logic [WIDTH+1:0] diff;

   always_comb begin
      mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, b_mag} : '0);
      // Divide: upper half is the partial remainder, lower half shifts dividend out and quotient in.
      rem_trial = acc[2*WIDTH-1:WIDTH-1];
      diff      = {1'b0, rem_trial} - {2'b00, b_mag};
      q_bit     = 1'b0;
      acc_next  = {mul_sum, acc[WIDTH-1:1]};
      if (op == MDU_DIV) begin
         q_bit    = ~diff[WIDTH+1];
         acc_next = {(q_bit ? diff[WIDTH-1:0] : rem_trial[WIDTH-1:0]), acc[WIDTH-2:0], q_bit};
      end
   end
endmodule

// File: rtl/mul_div_unit.sv
// Iterative 16-bit signed multiply/divide feeding the register file write port.
module mul_div_unit
   import mdu_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 halt_sys,
   input  logic                 start,
   input  logic                 op,
   input  logic [3:0]           dest_addr,
   input  logic [WIDTH-1:0]     opa,
   input  logic [WIDTH-1:0]     opb,
   output logic                 busy,
   output logic                 write_en,
   output logic                 R0_en,
   output logic [3:0]           write_address,
   output logic [2*WIDTH-1:0]   write_data,
   output logic                 div_zero
);
   mdu_state_t         state_reg, state_next;
   logic [CNT_W-1:0]   cnt_reg, cnt_next;
   mdu_op_t            op_reg, op_next;
   logic [3:0]         dest_reg, dest_next;
   logic [WIDTH-1:0]   b_mag_reg, b_mag_next;
   logic [2*WIDTH-1:0] acc_reg, acc_next;
   logic               neg_q_reg, neg_q_next;
   logic               neg_r_reg, neg_r_next;
   logic               b_zero_reg, b_zero_next;
   logic               we_reg, we_next;
   logic               r0_reg, r0_next;
   logic [3:0]         waddr_reg, waddr_next;
   logic [2*WIDTH-1:0] wdata_reg, wdata_next;
   logic               dz_reg, dz_next;

   logic [2*WIDTH-1:0] core_acc;
   logic               core_q;
   logic [WIDTH-1:0]   q_fix, r_fix;
   logic [2*WIDTH-1:0] prod_fix;

   mdu_iter_core u_core (
      .op       (op_reg),
      .acc      (acc_reg),
      .b_mag    (b_mag_reg),
      .acc_next (core_acc),
      .q_bit    (core_q)
   );

   always_comb begin
      state_next  = state_reg;
      cnt_next    = cnt_reg;
      op_next     = op_reg;
      dest_next   = dest_reg;
      b_mag_next  = b_mag_reg;
      acc_next    = acc_reg;
      neg_q_next  = neg_q_reg;
      neg_r_next  = neg_r_reg;
      b_zero_next = b_zero_reg;
      we_next     = we_reg;
      r0_next     = r0_reg;
      waddr_next  = waddr_reg;
      wdata_next  = wdata_reg;
      dz_next     = dz_reg;
      prod_fix    = neg_q_reg ? -acc_reg : acc_reg;
      // A zero divisor leaves the dividend magnitude as remainder; only the quotient is forced.
      q_fix       = b_zero_reg ? '1 : (neg_q_reg ? -acc_reg[WIDTH-1:0] : acc_reg[WIDTH-1:0]);
      r_fix       = neg_r_reg ? -acc_reg[2*WIDTH-1:WIDTH] : acc_reg[2*WIDTH-1:WIDTH];

      case (state_reg)
         IDLE: begin
            if (start) begin
               op_next     = mdu_op_t'(op);
               dest_next   = dest_addr;
               b_mag_next  = mag(opb);
               acc_next    = {{WIDTH{1'b0}}, mag(opa)};
               neg_q_next  = opa[WIDTH-1] ^ opb[WIDTH-1];
               neg_r_next  = opa[WIDTH-1];
               b_zero_next = (opb == '0);
               cnt_next    = '0;
               state_next  = CALC;
            end
         end
         CALC: begin
            acc_next = core_acc;
            cnt_next = cnt_reg + 1'b1;
            if (cnt_reg == CNT_W'(ITER - 1))
               state_next = FIX;
         end
         FIX: begin
            wdata_next = (op_reg == MDU_MUL) ? prod_fix : {r_fix, q_fix};
            waddr_next = dest_reg;
            we_next    = 1'b1;
            r0_next    = 1'b1;
            dz_next    = (op_reg == MDU_DIV) && b_zero_reg;
            state_next = DONE;
         end
         DONE: begin
            we_next    = 1'b0;
            r0_next    = 1'b0;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // A halted edge holds everything, which also keeps write_en up until the register file can take it.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg  <= IDLE;
         cnt_reg    <= '0;
         op_reg     <= MDU_MUL;
         dest_reg   <= '0;
         b_mag_reg  <= '0;
         acc_reg    <= '0;
         neg_q_reg  <= 1'b0;
         neg_r_reg  <= 1'b0;
         b_zero_reg <= 1'b0;
         we_reg     <= 1'b0;
         r0_reg     <= 1'b0;
         waddr_reg  <= '0;
         wdata_reg  <= '0;
         dz_reg     <= 1'b0;
      end else if (!halt_sys) begin
         state_reg  <= state_next;
         cnt_reg    <= cnt_next;
         op_reg     <= op_next;
         dest_reg   <= dest_next;
         b_mag_reg  <= b_mag_next;
         acc_reg    <= acc_next;
         neg_q_reg  <= neg_q_next;
         neg_r_reg  <= neg_r_next;
         b_zero_reg <= b_zero_next;
         we_reg     <= we_next;
         r0_reg     <= r0_next;
         waddr_reg  <= waddr_next;
         wdata_reg  <= wdata_next;
         dz_reg     <= dz_next;
      end
   end

   assign busy          = (state_reg != IDLE);
   assign write_en      = we_reg;
   assign R0_en         = r0_reg;
   assign write_address = waddr_reg;
   assign write_data    = wdata_reg;
   assign div_zero      = dz_reg;
endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit.
module tb_mul_div_unit;
   logic        clk = 1'b0;
   logic        rst, halt_sys, start, op;
   logic [3:0]  dest_addr;
   logic [15:0] opa, opb;
   logic        busy, write_en, R0_en, div_zero;
   logic [3:0]  write_address;
   logic [31:0] write_data;
   int          checks = 0;
   int          failures = 0;

   mul_div_unit dut (
      .clk(clk), .rst(rst), .halt_sys(halt_sys), .start(start), .op(op),
      .dest_addr(dest_addr), .opa(opa), .opb(opb), .busy(busy),
      .write_en(write_en), .R0_en(R0_en), .write_address(write_address),
      .write_data(write_data), .div_zero(div_zero)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one operation and wait (bounded) for write_en; lat counts edges after the accept edge.
   task automatic run_op(input logic o, input logic [15:0] a, input logic [15:0] b,
                         input logic [3:0] d, output int lat);
      op = o; opa = a; opb = b; dest_addr = d; start = 1'b1;
      tick();
      start = 1'b0; opa = 16'h5A5A; opb = 16'hA5A5; dest_addr = 4'hF;
      lat = 0;
      while (write_en !== 1'b1 && lat < 40) begin
         tick();
         lat++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      checks++;
      if ({busy, write_en, R0_en, div_zero, write_address, write_data} !== 40'd0) begin
         failures++;
         $display("FAIL reset_outputs got=%h exp=0", {busy, write_en, R0_en, div_zero, write_address, write_data});
      end
   endtask

   task automatic test_mul();
      logic [15:0] va [3] = '{16'h0003, 16'h7FFF, 16'h8000};
      logic [15:0] vb [3] = '{16'hFFFC, 16'h7FFF, 16'h8000};
      logic [31:0] ve [3] = '{32'hFFFF_FFF4, 32'h3FFF_0001, 32'h4000_0000};
      int lat;
      for (int i = 0; i < 3; i++) begin
         run_op(1'b0, va[i], vb[i], 4'(5 + i), lat);
         checks++;
         if (lat != 17) begin failures++; $display("FAIL mul_latency[%0d] got=%0d exp=17", i, lat); end
         checks++;
         if (write_data !== ve[i]) begin failures++; $display("FAIL mul_data[%0d] got=%h exp=%h", i, write_data, ve[i]); end
         checks++;
         if (write_address !== 4'(5 + i) || R0_en !== 1'b1) begin
            failures++; $display("FAIL mul_addr_r0[%0d] got=%h/%b exp=%h/1", i, write_address, R0_en, 4'(5 + i));
         end
         tick();
         checks++;
         if (write_en !== 1'b0 || R0_en !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL mul_done[%0d] got we=%b r0=%b busy=%b exp 0/0/0", i, write_en, R0_en, busy);
         end
         $display("mul %h * %h -> %h lat=%0d", va[i], vb[i], write_data, lat);
      end
   endtask

   task automatic test_div();
      logic [15:0] va [5] = '{16'hFFF9, 16'd100, 16'd100, 16'd9, 16'h8000};
      logic [15:0] vb [5] = '{16'd2, 16'd7, 16'd0, 16'd3, 16'hFFFF};
      logic [31:0] ve [5] = '{32'hFFFF_FFFD, 32'h0002_000E, 32'h0064_FFFF, 32'h0000_0003, 32'h0000_8000};
      logic        vz [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      int lat;
      for (int i = 0; i < 5; i++) begin
         run_op(1'b1, va[i], vb[i], 4'd0, lat);
         checks++;
         if (lat != 17) begin failures++; $display("FAIL div_latency[%0d] got=%0d exp=17", i, lat); end
         checks++;
         if (write_data !== ve[i]) begin failures++; $display("FAIL div_data[%0d] got=%h exp=%h", i, write_data, ve[i]); end
         checks++;
         if (div_zero !== vz[i]) begin failures++; $display("FAIL div_zero[%0d] got=%b exp=%b", i, div_zero, vz[i]); end
         tick();
         $display("div %h / %h -> %h dz=%b lat=%0d", va[i], vb[i], write_data, div_zero, lat);
      end
   endtask

   task automatic test_halt_idle();
      op = 1'b0; opa = 16'd2; opb = 16'd2; halt_sys = 1'b1; start = 1'b1;
      tick();
      start = 1'b0; halt_sys = 1'b0;
      tick();
      checks++;
      if (busy !== 1'b0) begin failures++; $display("FAIL halt_idle_accept got busy=%b exp=0", busy); end
      $display("start under halt in IDLE: busy=%b", busy);
   endtask

   task automatic test_halt_calc();
      int lat;
      op = 1'b0; opa = 16'd7; opb = 16'd6; dest_addr = 4'd3; start = 1'b1;
      tick();
      start = 1'b0;
      tick(); tick(); tick();
      halt_sys = 1'b1;
      repeat (5) tick();
      halt_sys = 1'b0;
      lat = 8;
      while (write_en !== 1'b1 && lat < 60) begin
         tick();
         lat++;
      end
      checks++;
      if (lat != 22) begin failures++; $display("FAIL halt_calc_latency got=%0d exp=22", lat); end
      checks++;
      if (write_data !== 32'h0000_002A) begin failures++; $display("FAIL halt_calc_data got=%h exp=0000002a", write_data); end
      tick();
      $display("halt in CALC: latency=%0d data=%h", lat, write_data);
   endtask

   task automatic test_halt_done();
      int lat;
      int hi;
      run_op(1'b1, 16'd100, 16'd7, 4'd2, lat);
      hi = (write_en === 1'b1) ? 1 : 0;
      halt_sys = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (write_en === 1'b1) hi++;
      end
      halt_sys = 1'b0;
      tick();
      if (write_en === 1'b1) hi++;
      checks++;
      if (hi != 4) begin failures++; $display("FAIL halt_done_we_cycles got=%0d exp=4", hi); end
      checks++;
      if (write_data !== 32'h0002_000E || busy !== 1'b0) begin
         failures++; $display("FAIL halt_done_hold got data=%h busy=%b exp 0002000e/0", write_data, busy);
      end
      $display("halt in DONE: write_en high %0d cycles", hi);
   endtask

   task automatic test_start_ignored();
      int lat;
      op = 1'b0; opa = 16'hFFFF; opb = 16'hFFFF; dest_addr = 4'd7; start = 1'b1;
      tick();
      checks++;
      if (busy !== 1'b1) begin failures++; $display("FAIL busy_after_accept got=%b exp=1", busy); end
      op = 1'b1; opa = 16'd5; opb = 16'd5; dest_addr = 4'd1;
      repeat (4) tick();
      start = 1'b0;
      lat = 4;
      while (write_en !== 1'b1 && lat < 40) begin
         tick();
         lat++;
      end
      checks++;
      if (lat != 17 || write_data !== 32'h0000_0001 || write_address !== 4'd7) begin
         failures++; $display("FAIL start_busy_result got lat=%0d data=%h addr=%h exp 17/00000001/7", lat, write_data, write_address);
      end
      repeat (4) tick();
      checks++;
      if (busy !== 1'b0) begin failures++; $display("FAIL start_busy_no_queue got busy=%b exp=0", busy); end
      $display("start while busy: lat=%0d data=%h", lat, write_data);
   endtask

   task automatic test_reset_mid();
      int lat;
      int seen;
      run_op(1'b1, 16'd50, 16'd0, 4'd4, lat);
      tick();
      checks++;
      if (div_zero !== 1'b1) begin failures++; $display("FAIL reset_mid_pre_dz got=%b exp=1", div_zero); end
      op = 1'b0; opa = 16'h0100; opb = 16'h0100; dest_addr = 4'd9; start = 1'b1;
      tick();
      start = 1'b0;
      repeat (7) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if ({busy, write_en, R0_en, div_zero, write_address, write_data} !== 40'd0) begin
         failures++;
         $display("FAIL reset_mid_outputs got=%h exp=0", {busy, write_en, R0_en, div_zero, write_address, write_data});
      end
      seen = 0;
      repeat (25) begin
         tick();
         if (write_en === 1'b1) seen++;
      end
      checks++;
      if (seen != 0) begin failures++; $display("FAIL reset_mid_no_write got=%0d exp=0", seen); end
      run_op(1'b0, 16'h0100, 16'h0100, 4'd9, lat);
      checks++;
      if (lat != 17 || write_data !== 32'h0001_0000 || write_address !== 4'd9) begin
         failures++; $display("FAIL reset_mid_restart got lat=%0d data=%h addr=%h exp 17/00010000/9", lat, write_data, write_address);
      end
      tick();
      $display("reset mid-op: restart lat=%0d data=%h", lat, write_data);
   endtask

   initial begin
      rst = 1'b1; halt_sys = 1'b0; start = 1'b0; op = 1'b0;
      dest_addr = '0; opa = '0; opb = '0;
      #1;
      test_reset();
      test_mul();
      test_div();
      test_halt_idle();
      test_halt_calc();
      test_halt_done();
      test_start_ignored();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
